// File: rtl/address_sequencer.sv
// Handshaked address source: linear-with-wrap, Fibonacci LFSR, Galois LFSR and fixed modes.
// Define ADDRESS_SEQUENCER_LFSR_ZERO_GUARD_EN to reload the seed when an LFSR step yields zero.
module address_sequencer #(
    parameter int WIDTH       = 48,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       range_start,
    input  logic [WIDTH-1:0]       range_increment,
    input  logic [WIDTH-1:0]       range_limit,
    input  logic [WIDTH-1:0]       lfsr_seed,
    input  logic [WIDTH-1:0]       lfsr_taps,
    input  logic [WIDTH-1:0]       lfsr_mask,
    input  logic [WIDTH-1:0]       final_mask,
    input  logic [COUNT_WIDTH-1:0] address_count,
    output logic [WIDTH-1:0]       address,
    output logic                   address_valid,
    input  logic                   address_ready,
    output logic                   address_last,
    output logic                   busy,
    output logic                   done,
    output logic                   lfsr_lockup
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam logic [1:0] M_LINEAR = 2'b00;
    localparam logic [1:0] M_FIB    = 2'b01;
    localparam logic [1:0] M_GALOIS = 2'b10;
    localparam logic [1:0] M_FIXED  = 2'b11;

    logic                   state_q;
    logic [1:0]             mode_q;
    logic [WIDTH-1:0]       start_q;
    logic [WIDTH-1:0]       inc_q;
    logic [WIDTH-1:0]       limit_q;
    logic [WIDTH-1:0]       taps_q;
    logic [WIDTH-1:0]       lmask_q;
    logic [WIDTH-1:0]       addr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] beat_q;
    logic                   done_q;

    logic                   capture;
    logic                   transfer;
    logic                   last;
    logic [WIDTH:0]         lin_sum;
    logic [WIDTH-1:0]       lin_next;
    logic [WIDTH-1:0]       raw_next;
    logic [WIDTH-1:0]       next_addr;

    assign busy          = (state_q == S_RUN);
    assign address_valid = busy;
    assign address       = addr_q & final_mask;
    assign done          = done_q;
    assign capture       = !busy && start && !stop;
    assign transfer      = busy && address_ready;
    assign last          = busy && (count_q != '0) && (beat_q == count_q - COUNT_WIDTH'(1));
    assign address_last  = last;

    // Carry out of the WIDTH+1-bit sum counts as exceeding the limit.
    assign lin_sum  = {1'b0, addr_q} + {1'b0, inc_q};
    assign lin_next = (lin_sum[WIDTH] || (lin_sum[WIDTH-1:0] > limit_q)) ? start_q
                                                                         : lin_sum[WIDTH-1:0];

    always_comb begin
        raw_next = addr_q;
        case (mode_q)
            M_LINEAR: raw_next = lin_next;
            M_FIB:    raw_next = lmask_q & {^(addr_q & taps_q), addr_q[WIDTH-1:1]};
            M_GALOIS: raw_next = lmask_q & ((addr_q >> 1) ^ ({WIDTH{addr_q[0]}} & taps_q));
            M_FIXED:  raw_next = addr_q;
            default:  raw_next = addr_q;
        endcase
    end

`ifdef ADDRESS_SEQUENCER_LFSR_ZERO_GUARD_EN
    logic [WIDTH-1:0] seed_q;
    logic             lockup_q;
    logic             guard_hit;

    assign guard_hit   = ((mode_q == M_FIB) || (mode_q == M_GALOIS)) && (raw_next == '0);
    assign next_addr   = guard_hit ? (seed_q & lmask_q) : raw_next;
    assign lfsr_lockup = lockup_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seed_q   <= '0;
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= transfer && guard_hit;
            if (capture) seed_q <= lfsr_seed;
        end
    end
`else
    assign next_addr   = raw_next;
    assign lfsr_lockup = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            start_q <= '0;
            inc_q   <= '0;
            limit_q <= '0;
            taps_q  <= '0;
            lmask_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        state_q <= S_RUN;
                        mode_q  <= mode;
                        start_q <= range_start;
                        inc_q   <= range_increment;
                        limit_q <= range_limit;
                        taps_q  <= lfsr_taps;
                        lmask_q <= lfsr_mask;
                        count_q <= address_count;
                        beat_q  <= '0;
                        addr_q  <= ((mode == M_FIB) || (mode == M_GALOIS)) ? (lfsr_seed & lfsr_mask)
                                                                           : range_start;
                    end
                end
                S_RUN: begin
                    if (transfer) begin
                        addr_q <= next_addr;
                        if (beat_q != '1) beat_q <= beat_q + COUNT_WIDTH'(1);
                    end
                    // NOTE: stop takes priority over a concurrent final transfer, so no done pulse.
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (transfer && last) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Scoreboard bench for address_sequencer: a 16-bit instance for linear/Galois/random runs and a
// 4-bit instance for the short Fibonacci sequence; expected beats come from a spec-level model.
module tb_address_sequencer;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic        stop   = 1'b0;
    logic        ready  = 1'b0;
    logic        sel    = 1'b0;
    logic [1:0]  mode   = 2'b00;
    logic [15:0] r_start = '0, r_inc = '0, r_limit = '0;
    logic [15:0] seed = '0, taps = '0, lmask = '0, fmask = 16'hFFFF, count = '0;

    logic [15:0] a16;
    logic        v16, l16, b16, d16, k16;
    logic [3:0]  a4;
    logic        v4, l4, b4, d4, k4;

    address_sequencer #(.WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clock(clock), .resetn(resetn), .start(start && !sel), .stop(stop), .mode(mode),
        .range_start(r_start), .range_increment(r_inc), .range_limit(r_limit),
        .lfsr_seed(seed), .lfsr_taps(taps), .lfsr_mask(lmask), .final_mask(fmask),
        .address_count(count), .address(a16), .address_valid(v16), .address_ready(ready),
        .address_last(l16), .busy(b16), .done(d16), .lfsr_lockup(k16)
    );

    address_sequencer #(.WIDTH(4), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .resetn(resetn), .start(start && sel), .stop(stop), .mode(mode),
        .range_start(r_start[3:0]), .range_increment(r_inc[3:0]), .range_limit(r_limit[3:0]),
        .lfsr_seed(seed[3:0]), .lfsr_taps(taps[3:0]), .lfsr_mask(lmask[3:0]),
        .final_mask(fmask[3:0]), .address_count(count[3:0]), .address(a4), .address_valid(v4),
        .address_ready(ready), .address_last(l4), .busy(b4), .done(d4), .lfsr_lockup(k4)
    );

    always #5 clock = ~clock;

    logic [15:0] m_addr;
    logic        m_valid, m_last, m_busy, m_done, m_lock;
    assign m_addr  = sel ? {12'h000, a4} : a16;
    assign m_valid = sel ? v4 : v16;
    assign m_last  = sel ? l4 : l16;
    assign m_busy  = sel ? b4 : b16;
    assign m_done  = d4 | d16;
    assign m_lock  = k4 | k16;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        last;
        logic        lock;
    } exp_t;
    exp_t q[$];

    // Reference next-state rules, evaluated on a w-bit register held in 16 bits.
    function automatic logic [15:0] model_next(input logic [1:0] md, input logic [15:0] a,
                                               input int w, output logic lock);
        logic [16:0] n;
        logic [15:0] r;
        logic        f;
        lock = 1'b0;
        r    = a;
        case (md)
            2'd0: begin
                n = {1'b0, a} + {1'b0, r_inc};
                r = (n > {1'b0, r_limit}) ? r_start : n[15:0];
            end
            2'd1: begin
                f = ^(a & taps);
                r = lmask & ((16'(f) << (w - 1)) | (a >> 1));
            end
            2'd2: r = lmask & ((a >> 1) ^ (a[0] ? taps : 16'h0000));
            default: r = a;
        endcase
`ifdef ADDRESS_SEQUENCER_LFSR_ZERO_GUARD_EN
        if ((md == 2'd1 || md == 2'd2) && r == 16'h0000) begin
            r    = seed & lmask;
            lock = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic gen(input int n, input int w);
        logic [15:0] a;
        logic        lk;
        exp_t        e;
        a = (mode == 2'd1 || mode == 2'd2) ? (seed & lmask) : r_start;
        for (int i = 0; i < n; i++) begin
            e.addr = a;
            e.last = (count != 0) && (i == int'(count) - 1);
            a      = model_next(mode, a, w, lk);
            e.lock = lk;
            q.push_back(e);
        end
    endtask

    // Monitor: pops one expected beat per observed transfer; done/lockup follow one edge later.
    logic        pend_done = 1'b0, pend_lock = 1'b0, hold = 1'b0;
    logic [15:0] hold_addr = '0;
    bit          collect = 1'b0;
    bit          seen[256];
    int          distinct = 0;
    exp_t        me;

    always @(negedge clock) begin
        if (!resetn) begin
            pend_done = 1'b0;
            pend_lock = 1'b0;
            hold      = 1'b0;
        end else begin
            check("done", m_done, pend_done);
            check("lfsr_lockup", m_lock, pend_lock);
            pend_done = 1'b0;
            pend_lock = 1'b0;
            if (hold && m_valid) check("hold_stable", m_addr, hold_addr);
            if (m_valid && ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transfer: got address %0h with empty queue", m_addr);
                end else begin
                    me = q.pop_front();
                    check("address", m_addr, me.addr & fmask);
                    check("last", m_last, me.last);
                    pend_done = me.last;
                    pend_lock = me.lock;
                    if (collect && !seen[m_addr[7:0]]) begin
                        seen[m_addr[7:0]] = 1'b1;
                        distinct++;
                    end
                end
            end
            hold      = m_valid && !ready;
            hold_addr = m_addr;
        end
    end

    // pct: ready probability in percent, negative = toggle. stop_after >= 0: unbounded run, stop then.
    task automatic run(input bit s, input logic [1:0] md, input logic [15:0] st, input logic [15:0] inc,
                       input logic [15:0] lim, input logic [15:0] sd, input logic [15:0] tp,
                       input logic [15:0] lm, input logic [15:0] fm, input logic [15:0] cnt,
                       input int pct, input int stop_after);
        int n;
        bit finished;
        sel = s; mode = md; r_start = st; r_inc = inc; r_limit = lim;
        seed = sd; taps = tp; lmask = lm; fmask = fm; count = cnt;
        gen((cnt != 0) ? int'(cnt) : stop_after + 4, s ? 4 : 16);
        ready = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("valid_after_start", m_valid, 1'b1);
        n        = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!m_busy) begin
                finished = 1'b1;
                break;
            end
            if (stop_after >= 0 && n == stop_after) begin
                ready = 1'b0;
                stop  = 1'b1;
            end else if (pct < 0) begin
                ready = ~ready;
            end else begin
                ready = ($urandom_range(0, 99) < pct);
            end
            if (m_valid && ready) n++;
            @(posedge clock); #1;
            if (stop) begin
                stop = 1'b0;
                check("stop_idle_next", m_busy, 1'b0);
            end
        end
        check("run_terminates", finished, 1'b1);
        ready = 1'b0;
        if (cnt != 0) begin
            check("transfer_count", n, int'(cnt));
            check("queue_drained", q.size(), 0);
        end else begin
            check("unbounded_transfers", n, stop_after);
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3;
        check("reset_valid", m_valid, 1'b0);
        check("reset_busy", m_busy, 1'b0);
        check("reset_address", a16, 16'h0000);
        check("reset_done", m_done, 1'b0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // start together with stop in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", m_busy, 1'b0);

        // Linear 0x10/0x10/0x30 x5, then the same with toggling ready
        run(0, 2'd0, 16'h0010, 16'h0010, 16'h0030, 0, 0, 0, 16'hFFFF, 5, 100, -1);
        run(0, 2'd0, 16'h0010, 16'h0010, 16'h0030, 0, 0, 0, 16'hFFFF, 5, -1, -1);
        // Linear carry out wraps to range_start
        run(0, 2'd0, 16'hFFF0, 16'h0020, 16'hFFFF, 0, 0, 0, 16'hFFFF, 4, 100, -1);

        // Galois 8-bit maximal sequence: 255 distinct values, 256th returns to the seed
        collect  = 1'b1;
        distinct = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        run(0, 2'd2, 0, 0, 0, 16'h0001, 16'h00B8, 16'h00FF, 16'hFFFF, 256, 100, -1);
        collect = 1'b0;
        check("galois_distinct", distinct, 255);

        // Fibonacci 4-bit unbounded, stopped after 20 transfers
        run(1, 2'd1, 0, 0, 0, 16'h0001, 16'h0003, 16'h000F, 16'hFFFF, 0, 100, 20);
        repeat (2) @(posedge clock);
        #1;

        // Zero-state guard: Galois with no taps collapses to zero after the seed
        run(0, 2'd2, 0, 0, 0, 16'h0001, 16'h0000, 16'h00FF, 16'hFFFF, 4, 100, -1);

        // Fixed mode and a live final_mask
        run(0, 2'd3, 16'hA5C3, 0, 0, 0, 0, 0, 16'h0FF0, 3, 70, -1);

        // Reset mid-run after three transfers
        sel = 1'b0; mode = 2'd0; r_start = 16'h0010; r_inc = 16'h0010; r_limit = 16'h0030;
        fmask = 16'hFFFF; count = 5;
        gen(5, 16);
        ready = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_address", a16, 16'h0000);
        check("midreset_valid", v16, 1'b0);
        check("midreset_busy", b16, 1'b0);
        check("midreset_last", l16, 1'b0);
        check("midreset_done", d16, 1'b0);
        check("midreset_remaining", q.size(), 2);
        q.delete();
        ready = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        run(0, 2'd0, 16'h0010, 16'h0010, 16'h0030, 0, 0, 0, 16'hFFFF, 5, 100, -1);

        // Random back-to-back runs on the 16-bit instance
        for (int r = 0; r < 10; r++) begin
            run(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(1, 16'h3000)),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                (r % 2 == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom_range(1, 24)),
                $urandom_range(40, 100), -1);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
